axi_hp_mem_responder: RTL and testbench
=======================================

// Module: axi_hp_mem_responder
// PURPOSE
//  AXI3 HP-port slave backed by a dual-port word RAM; the responder end of DramReader/DramWriterBuf bursts.
//  Stands in for PS7 DDR on an HP port, so reader -> app -> writer pipelines run stand-alone.
//  Read and write channels are independent. One burst in flight per direction, no IDs.
// PARAMETERS
//  DEPTH      1024         number of 64-bit words in the RAM
//  BASE_ADDR  32'h1000_0000 byte address of word 0
// PORTS
//  fclk            in   1   clock; all logic rising-edge
//  rst             in   1   reset, asynchronous, active-high
//  S_AXI_AWADDR    in   32  write burst start byte address
//  S_AXI_AWLEN     in   4   beats-1
//  S_AXI_AWSIZE    in   3   must be 3 (8 B)
//  S_AXI_AWBURST   in   2   must be 2'b01 (INCR)
//  S_AXI_AWVALID/AWREADY  in/out 1  AW handshake
//  S_AXI_WDATA     in   64  write data
//  S_AXI_WSTRB     in   8   byte enables
//  S_AXI_WLAST     in   1   last write beat
//  S_AXI_WVALID/WREADY    in/out 1  W handshake
//  S_AXI_BRESP     out  2   2'b00 OKAY, 2'b10 SLVERR
//  S_AXI_BVALID/BREADY    out/in 1  B handshake
//  S_AXI_ARADDR/ARLEN/ARSIZE/ARBURST  in 32/4/3/2  read burst, same rules as AW
//  S_AXI_ARVALID/ARREADY  in/out 1  AR handshake
//  S_AXI_RDATA     out  64  read data
//  S_AXI_RRESP     out  2   per-beat response
//  S_AXI_RLAST     out  1   last read beat
//  S_AXI_RVALID/RREADY    out/in 1  R handshake
//  dbg_wr_beats    out  32  count of accepted W beats, wraps
//  dbg_rd_beats    out  32  count of completed R beats, wraps
// BEHAVIOUR
//  Reset: every READY/VALID output, BRESP, RRESP, RDATA, RLAST and dbg counters = 0. RAM contents are not reset.
//  Reset mid-burst: both FSMs go to IDLE. The partial burst is abandoned and no B/R completion is issued.
//  Addressing:
//   - word = (addr-BASE_ADDR)>>3; addr[2:0] ignored; the word index increments by 1 per beat.
//   - Range check is per beat: word >= DEPTH or addr < BASE_ADDR is out of range.
//  Write FSM W_IDLE/W_DATA/W_RESP:
//   - W_IDLE: AWREADY=1. On handshake latch addr, len and bad = (AWSIZE!=3 | AWBURST!=INCR); go to W_DATA.
//   - W_DATA: WREADY=1. Each beat writes bytes per WSTRB at the current word, unless bad or out of range.
//   - Error: an out-of-range beat sets err. WLAST on a beat other than len, or no WLAST by beat len, also sets err.
//   - Beats are accepted until the WLAST handshake, then go to W_RESP.
//   - W_RESP: BVALID=1 from the cycle after WLAST. BRESP = (bad|err)?SLVERR:OKAY. Hold until BREADY, then W_IDLE.
//  Read FSM R_IDLE/R_FETCH/R_DATA:
//   - R_IDLE: ARREADY=1. On handshake latch addr, len and bad; go to R_FETCH.
//   - R_FETCH: issue the RAM read (1-cycle sync read), then go to R_DATA.
//   - Latency: AR handshake at cycle N -> RVALID at N+2.
//   - R_DATA: RDATA/RRESP/RLAST are registered and held stable while RVALID & !RREADY.
//   - On an R handshake the next word's read is issued the same cycle, giving 1 beat/cycle when RREADY is held high.
//   - RLAST on beat len; its handshake returns to R_IDLE.
//   - A bad or out-of-range beat returns RDATA=0, RRESP=SLVERR.
//  Same word written and read in one cycle: the read returns old data (read-first).
//  An AR handshake is never accepted while in R_FETCH or R_DATA. The same applies to AW outside W_IDLE.
// CONFIGURATION
//  AXI_MEM_STALL_EN defined:
//   - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1, advances every cycle after reset.
//   - While lfsr[0]=1: AWREADY, ARREADY and WREADY are forced 0, and no new R beat is presented.
//   - A presented RVALID is never withdrawn before its handshake.
//  AXI_MEM_STALL_EN undefined: no LFSR; ready/valid timing exactly as above.
// STRUCTURE
//  Package axi_mem_pkg: RESP_OKAY/RESP_SLVERR, BURST_INCR, SIZE_8B constants; wstate_t and rstate_t enums.
//  Sub-module axi_mem_ram: true dual-port RAM, 64-bit, byte-write port A, read-first sync read port B.
// TESTING
//  - Write AWADDR=BASE, AWLEN=3, data 1..4, WSTRB=8'hFF -> BRESP=OKAY. Then read 4 beats from BASE -> 1,2,3,4, RLAST on 4th, dbg_wr_beats=4, dbg_rd_beats=4.
//  - RREADY held 1, ARLEN=15 -> 16 consecutive RVALID cycles starting AR+2, no bubbles.
//  - RREADY toggled every other cycle -> RDATA stable while stalled, order preserved.
//  - Write WSTRB=8'h0F, data 64'hFFFF_FFFF_FFFF_FFFF over word 64'h0 -> readback 64'h0000_0000_FFFF_FFFF.
//  - AWADDR=BASE+(DEPTH-2)*8, AWLEN=3 -> words DEPTH-2 and DEPTH-1 written, others dropped, BRESP=SLVERR.
//  - Same burst read -> RRESP OKAY,OKAY,SLVERR,SLVERR.
//  - AWSIZE=2 -> all beats consumed, RAM unchanged, BRESP=SLVERR.
//  - rst pulsed mid 8-beat read after beat 3 -> RVALID=0 next cycle, ARREADY=1 after release, no stray RLAST.

Source files
------------

// File: rtl/axi_mem_pkg.sv
// Shared constants and FSM state types for the HP-port memory responder.
package axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_8B     = 3'd3;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DATA
    } rstate_t;

endpackage

// File: rtl/axi_hp_mem_responder_if.sv
// AXI3 HP-port signal bundle; slave modport for the responder, master for the requester.
interface axi_hp_mem_responder_if;

    logic [31:0] S_AXI_AWADDR;
    logic [3:0]  S_AXI_AWLEN;
    logic [2:0]  S_AXI_AWSIZE;
    logic [1:0]  S_AXI_AWBURST;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [63:0] S_AXI_WDATA;
    logic [7:0]  S_AXI_WSTRB;
    logic        S_AXI_WLAST;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [31:0] S_AXI_ARADDR;
    logic [3:0]  S_AXI_ARLEN;
    logic [2:0]  S_AXI_ARSIZE;
    logic [1:0]  S_AXI_ARBURST;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [63:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY
    );

endinterface

// File: rtl/axi_mem_ram.sv
// Dual-port 64-bit word RAM: byte-enabled write port A, read-first synchronous read port B.
module axi_mem_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [63:0]   a_wdata,
    input  logic [7:0]    a_wstrb,
    input  logic          b_en,
    input  logic [AW-1:0] b_addr,
    output logic [63:0]   b_rdata_q
);

    logic [63:0] mem [DEPTH];

    // Non-blocking update makes a same-cycle read of the written word return the old value.
    always_ff @(posedge clk) begin
        if (a_we) begin
            for (int i = 0; i < 8; i++) begin
                if (a_wstrb[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
            end
        end
        if (b_en) b_rdata_q <= mem[b_addr];
    end

endmodule

// File: rtl/axi_hp_mem_responder.sv
// AXI3 HP slave backed by axi_mem_ram; independent read/write FSMs, one burst each.
// Optional AXI_MEM_STALL_EN inserts LFSR-driven ready/valid stalls.
module axi_hp_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic                         fclk,
    input  logic                         rst,
    axi_hp_mem_responder_if.slave        s_axi,
    output logic [31:0]                  dbg_wr_beats,
    output logic [31:0]                  dbg_rd_beats
);

    localparam int AW = $clog2(DEPTH);

    function automatic logic word_ok(input logic below, input logic [31:0] word);
        return !below && (word < 32'(DEPTH));
    endfunction

    logic stall;
`ifdef AXI_MEM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= lfsr_d;
    end
    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    wstate_t     wstate_q, wstate_d;
    logic [31:0] wword_q, wword_d, dbg_wr_q, dbg_wr_d;
    logic [3:0]  wlen_q, wlen_d, wbeat_q, wbeat_d;
    logic        wbelow_q, wbelow_d, wbad_q, wbad_d, werr_q, werr_d;
    logic        awready, wready, bvalid, ram_we;
    logic [1:0]  bresp;

    rstate_t     rstate_q, rstate_d;
    logic [31:0] rword_q, rword_d, dbg_rd_q, dbg_rd_d;
    logic [3:0]  rlen_q, rlen_d, rbeat_q, rbeat_d;
    logic        rbelow_q, rbelow_d, rbad_q, rbad_d;
    logic        rok_q, rok_d, rlast_q, rlast_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        arready, rvalid, ram_re;
    logic [63:0] ram_rdata;

    axi_mem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk       (fclk),
        .a_we      (ram_we),
        .a_addr    (wword_q[AW-1:0]),
        .a_wdata   (s_axi.S_AXI_WDATA),
        .a_wstrb   (s_axi.S_AXI_WSTRB),
        .b_en      (ram_re),
        .b_addr    (rword_q[AW-1:0]),
        .b_rdata_q (ram_rdata)
    );

    always_comb begin
        wstate_d = wstate_q;
        wword_d  = wword_q;
        wlen_d   = wlen_q;
        wbeat_d  = wbeat_q;
        wbelow_d = wbelow_q;
        wbad_d   = wbad_q;
        werr_d   = werr_q;
        dbg_wr_d = dbg_wr_q;
        awready  = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;
        bresp    = RESP_OKAY;
        ram_we   = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                awready = !stall;
                if (s_axi.S_AXI_AWVALID && !stall) begin
                    wword_d  = (s_axi.S_AXI_AWADDR - BASE_ADDR) >> 3;
                    wbelow_d = s_axi.S_AXI_AWADDR < BASE_ADDR;
                    wlen_d   = s_axi.S_AXI_AWLEN;
                    wbeat_d  = 4'd0;
                    wbad_d   = (s_axi.S_AXI_AWSIZE != SIZE_8B) || (s_axi.S_AXI_AWBURST != BURST_INCR);
                    werr_d   = 1'b0;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                wready = !stall;
                if (s_axi.S_AXI_WVALID && !stall) begin
                    ram_we = !wbad_q && word_ok(wbelow_q, wword_q);
                    // A WLAST that disagrees with the beat count flags the burst in either direction.
                    if (!word_ok(wbelow_q, wword_q) || (s_axi.S_AXI_WLAST != (wbeat_q == wlen_q)))
                        werr_d = 1'b1;
                    wword_d  = wword_q + 32'd1;
                    wbeat_d  = wbeat_q + 4'd1;
                    dbg_wr_d = dbg_wr_q + 32'd1;
                    if (s_axi.S_AXI_WLAST) wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                bresp  = (wbad_q || werr_q) ? RESP_SLVERR : RESP_OKAY;
                if (s_axi.S_AXI_BREADY) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rword_d  = rword_q;
        rlen_d   = rlen_q;
        rbeat_d  = rbeat_q;
        rbelow_d = rbelow_q;
        rbad_d   = rbad_q;
        rok_d    = rok_q;
        rlast_d  = rlast_q;
        rresp_d  = rresp_q;
        dbg_rd_d = dbg_rd_q;
        arready  = 1'b0;
        rvalid   = 1'b0;
        ram_re   = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                arready = !stall;
                if (s_axi.S_AXI_ARVALID && !stall) begin
                    rword_d  = (s_axi.S_AXI_ARADDR - BASE_ADDR) >> 3;
                    rbelow_d = s_axi.S_AXI_ARADDR < BASE_ADDR;
                    rlen_d   = s_axi.S_AXI_ARLEN;
                    rbeat_d  = 4'd0;
                    rbad_d   = (s_axi.S_AXI_ARSIZE != SIZE_8B) || (s_axi.S_AXI_ARBURST != BURST_INCR);
                    rstate_d = R_FETCH;
                end
            end
            R_FETCH: ram_re = !stall;
            R_DATA: begin
                rvalid = 1'b1;
                if (s_axi.S_AXI_RREADY) begin
                    dbg_rd_d = dbg_rd_q + 32'd1;
                    if (rlast_q) begin
                        rstate_d = R_IDLE;
                        rlast_d  = 1'b0;
                        rok_d    = 1'b0;
                        rresp_d  = RESP_OKAY;
                    end else if (!stall) begin
                        ram_re = 1'b1;
                    end else begin
                        rstate_d = R_FETCH;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        // The beat's response and RLAST are registered together with its RAM read.
        if (ram_re) begin
            rok_d    = !rbad_q && word_ok(rbelow_q, rword_q);
            rresp_d  = rok_d ? RESP_OKAY : RESP_SLVERR;
            rlast_d  = (rbeat_q == rlen_q);
            rword_d  = rword_q + 32'd1;
            rbeat_d  = rbeat_q + 4'd1;
            rstate_d = R_DATA;
        end
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            wstate_q <= W_IDLE;
            wbad_q   <= 1'b0;
            werr_q   <= 1'b0;
            dbg_wr_q <= '0;
            rstate_q <= R_IDLE;
            rbad_q   <= 1'b0;
            rok_q    <= 1'b0;
            rlast_q  <= 1'b0;
            rresp_q  <= RESP_OKAY;
            dbg_rd_q <= '0;
        end else begin
            wstate_q <= wstate_d;
            wbad_q   <= wbad_d;
            werr_q   <= werr_d;
            dbg_wr_q <= dbg_wr_d;
            rstate_q <= rstate_d;
            rbad_q   <= rbad_d;
            rok_q    <= rok_d;
            rlast_q  <= rlast_d;
            rresp_q  <= rresp_d;
            dbg_rd_q <= dbg_rd_d;
        end
    end

    always_ff @(posedge fclk) begin
        wword_q  <= wword_d;
        wlen_q   <= wlen_d;
        wbeat_q  <= wbeat_d;
        wbelow_q <= wbelow_d;
        rword_q  <= rword_d;
        rlen_q   <= rlen_d;
        rbeat_q  <= rbeat_d;
        rbelow_q <= rbelow_d;
    end

    // Ready outputs are held low for the whole reset pulse, not just after it.
    assign s_axi.S_AXI_AWREADY = awready && !rst;
    assign s_axi.S_AXI_WREADY  = wready && !rst;
    assign s_axi.S_AXI_BVALID  = bvalid && !rst;
    assign s_axi.S_AXI_BRESP   = bresp;
    assign s_axi.S_AXI_ARREADY = arready && !rst;
    assign s_axi.S_AXI_RVALID  = rvalid && !rst;
    assign s_axi.S_AXI_RDATA   = rok_q ? ram_rdata : 64'd0;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign s_axi.S_AXI_RLAST   = rlast_q;
    assign dbg_wr_beats        = dbg_wr_q;
    assign dbg_rd_beats        = dbg_rd_q;

endmodule

// File: tb/tb_axi_hp_mem_responder.sv
// Directed bench for axi_hp_mem_responder: bursts, strobes, range/size errors, reset mid-burst.
module tb_axi_hp_mem_responder;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          DEPTH = 1024;

    logic        fclk;
    logic        rst;
    logic [31:0] dbg_wr_beats, dbg_rd_beats;

    axi_hp_mem_responder_if bus ();

    axi_hp_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .fclk         (fclk),
        .rst          (rst),
        .s_axi        (bus.slave),
        .dbg_wr_beats (dbg_wr_beats),
        .dbg_rd_beats (dbg_rd_beats)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    int total = 0;
    int bad   = 0;
    int exp_wr = 0;
    int exp_rd = 0;

    logic [63:0] wd  [16];
    logic [63:0] rdv [16];
    logic [1:0]  rrv [16];
    logic        rlv [16];
    int r_first, r_bubbles, r_nbeats, r_unstable;

    task automatic axi_write(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                             input int nbeats, input logic [7:0] strb, output logic [1:0] resp);
        int n;
        resp = 2'bxx;
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_AWLEN   = len;
        bus.S_AXI_AWSIZE  = size;
        bus.S_AXI_AWBURST = 2'b01;
        bus.S_AXI_AWVALID = 1'b1;
        n = 0;
        while (!bus.S_AXI_AWREADY && n < 50) begin @(negedge fclk); n++; end
        @(negedge fclk);
        bus.S_AXI_AWVALID = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            bus.S_AXI_WDATA  = wd[b];
            bus.S_AXI_WSTRB  = strb;
            bus.S_AXI_WLAST  = (b == nbeats - 1);
            bus.S_AXI_WVALID = 1'b1;
            n = 0;
            while (!bus.S_AXI_WREADY && n < 50) begin @(negedge fclk); n++; end
            @(negedge fclk);
        end
        bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_WLAST  = 1'b0;
        exp_wr += nbeats;
        n = 0;
        while (!bus.S_AXI_BVALID && n < 50) begin @(negedge fclk); n++; end
        total++;
        if (!bus.S_AXI_BVALID) begin
            bad++;
            $display("FAIL write_bvalid_timeout addr=%h got BVALID=0 want 1", addr);
        end
        resp = bus.S_AXI_BRESP;
        bus.S_AXI_BREADY = 1'b1;
        @(negedge fclk);
        bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                            input bit toggle);
        int n, k;
        bit held;
        logic [63:0] held_data;
        r_first = -1; r_bubbles = 0; r_nbeats = 0; r_unstable = 0;
        held = 1'b0; held_data = '0;
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARLEN   = len;
        bus.S_AXI_ARSIZE  = size;
        bus.S_AXI_ARBURST = 2'b01;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY  = toggle ? 1'b0 : 1'b1;
        n = 0;
        while (!bus.S_AXI_ARREADY && n < 50) begin @(negedge fclk); n++; end
        @(negedge fclk);
        bus.S_AXI_ARVALID = 1'b0;
        k = 1;
        while (r_nbeats <= int'(len) && k < 200) begin
            if (toggle) bus.S_AXI_RREADY = ~bus.S_AXI_RREADY;
            if (bus.S_AXI_RVALID) begin
                if (r_first < 0) r_first = k;
                if (held && bus.S_AXI_RDATA !== held_data) r_unstable++;
                if (bus.S_AXI_RREADY) begin
                    rdv[r_nbeats] = bus.S_AXI_RDATA;
                    rrv[r_nbeats] = bus.S_AXI_RRESP;
                    rlv[r_nbeats] = bus.S_AXI_RLAST;
                    r_nbeats++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    held_data = bus.S_AXI_RDATA;
                end
            end else if (r_first >= 0) begin
                r_bubbles++;
            end
            @(negedge fclk);
            k++;
        end
        bus.S_AXI_RREADY = 1'b0;
        exp_rd += r_nbeats;
        total++;
        if (r_nbeats != int'(len) + 1) begin
            bad++;
            $display("FAIL read_beats addr=%h got %0d want %0d", addr, r_nbeats, int'(len) + 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge fclk);
        total++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_ARREADY,
             bus.S_AXI_RVALID, bus.S_AXI_RLAST} !== 6'b0 || bus.S_AXI_BRESP !== 2'b00 ||
            bus.S_AXI_RRESP !== 2'b00 || bus.S_AXI_RDATA !== 64'd0) begin
            bad++;
            $display("FAIL reset_outputs got rdy/vld=%b rdata=%h want all zero",
                     {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_ARREADY,
                      bus.S_AXI_RVALID, bus.S_AXI_RLAST}, bus.S_AXI_RDATA);
        end
        total++;
        if (dbg_wr_beats !== 32'd0 || dbg_rd_beats !== 32'd0) begin
            bad++;
            $display("FAIL reset_dbg got wr=%0d rd=%0d want 0 0", dbg_wr_beats, dbg_rd_beats);
        end
        rst = 1'b0;
        @(negedge fclk);
        total++;
        if (bus.S_AXI_AWREADY !== 1'b1 || bus.S_AXI_ARREADY !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got aw=%b ar=%b want 1 1",
                     bus.S_AXI_AWREADY, bus.S_AXI_ARREADY);
        end
    endtask

    task automatic test_basic();
        logic [1:0] resp;
        for (int i = 0; i < 4; i++) wd[i] = 64'(i + 1);
        axi_write(BASE, 4'd3, 3'd3, 4, 8'hFF, resp);
        total++;
        if (resp !== 2'b00) begin bad++; $display("FAIL basic_bresp got %b want 00", resp); end
        axi_read(BASE, 4'd3, 3'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rdv[i] !== 64'(i + 1) || rrv[i] !== 2'b00 || rlv[i] !== (i == 3)) begin
                bad++;
                $display("FAIL basic_beat%0d got data=%h resp=%b last=%b want %h 00 %b",
                         i, rdv[i], rrv[i], rlv[i], 64'(i + 1), (i == 3));
            end
        end
        total++;
        if (dbg_wr_beats !== 32'd4 || dbg_rd_beats !== 32'd4) begin
            bad++;
            $display("FAIL basic_dbg got wr=%0d rd=%0d want 4 4", dbg_wr_beats, dbg_rd_beats);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] resp;
        int errs;
        for (int i = 0; i < 16; i++) wd[i] = 64'h100 + 64'(i);
        axi_write(BASE + 32'h100, 4'd15, 3'd3, 16, 8'hFF, resp);
        axi_read(BASE + 32'h100, 4'd15, 3'd3, 1'b0);
        total++;
        if (r_first !== 2 || r_bubbles !== 0) begin
            bad++;
            $display("FAIL b2b_timing got first=%0d bubbles=%0d want 2 0", r_first, r_bubbles);
        end
        errs = 0;
        for (int i = 0; i < 16; i++) if (rdv[i] !== 64'h100 + 64'(i) || rlv[i] !== (i == 15)) errs++;
        total++;
        if (errs != 0) begin bad++; $display("FAIL b2b_data got %0d bad beats want 0", errs); end
    endtask

    task automatic test_rready_toggle();
        int errs;
        axi_read(BASE + 32'h100, 4'd15, 3'd3, 1'b1);
        total++;
        if (r_unstable != 0) begin
            bad++;
            $display("FAIL toggle_stable got %0d changes while stalled want 0", r_unstable);
        end
        errs = 0;
        for (int i = 0; i < 16; i++) if (rdv[i] !== 64'h100 + 64'(i)) errs++;
        total++;
        if (errs != 0) begin bad++; $display("FAIL toggle_order got %0d bad beats want 0", errs); end
    endtask

    task automatic test_strobe();
        logic [1:0] resp;
        wd[0] = 64'd0;
        axi_write(BASE + 32'h140, 4'd0, 3'd3, 1, 8'hFF, resp);
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        axi_write(BASE + 32'h140, 4'd0, 3'd3, 1, 8'h0F, resp);
        axi_read(BASE + 32'h140, 4'd0, 3'd3, 1'b0);
        total++;
        if (rdv[0] !== 64'h0000_0000_FFFF_FFFF) begin
            bad++;
            $display("FAIL strobe_data got %h want 00000000ffffffff", rdv[0]);
        end
    endtask

    task automatic test_range_edge();
        logic [1:0] resp;
        for (int i = 0; i < 4; i++) wd[i] = 64'hA0 + 64'(i);
        axi_write(BASE + 32'((DEPTH - 2) * 8), 4'd3, 3'd3, 4, 8'hFF, resp);
        total++;
        if (resp !== 2'b10) begin bad++; $display("FAIL edge_bresp got %b want 10", resp); end
        axi_read(BASE + 32'((DEPTH - 2) * 8), 4'd3, 3'd3, 1'b0);
        total++;
        if (rrv[0] !== 2'b00 || rrv[1] !== 2'b00 || rrv[2] !== 2'b10 || rrv[3] !== 2'b10) begin
            bad++;
            $display("FAIL edge_rresp got %b %b %b %b want 00 00 10 10", rrv[0], rrv[1], rrv[2], rrv[3]);
        end
        total++;
        if (rdv[0] !== 64'hA0 || rdv[1] !== 64'hA1 || rdv[2] !== 64'd0 || rdv[3] !== 64'd0) begin
            bad++;
            $display("FAIL edge_rdata got %h %h %h %h want a0 a1 0 0", rdv[0], rdv[1], rdv[2], rdv[3]);
        end
        axi_read(BASE, 4'd1, 3'd3, 1'b0);
        total++;
        if (rdv[0] !== 64'd1 || rdv[1] !== 64'd2) begin
            bad++;
            $display("FAIL edge_no_wrap got %h %h want 1 2", rdv[0], rdv[1]);
        end
    endtask

    task automatic test_bad_size();
        logic [1:0] resp;
        wd[0] = 64'h55;
        axi_write(BASE + 32'h190, 4'd0, 3'd3, 1, 8'hFF, resp);
        wd[0] = 64'hDEAD; wd[1] = 64'hBEEF;
        axi_write(BASE + 32'h190, 4'd1, 3'd2, 2, 8'hFF, resp);
        total++;
        if (resp !== 2'b10) begin bad++; $display("FAIL badsize_bresp got %b want 10", resp); end
        total++;
        if (dbg_wr_beats !== 32'(exp_wr)) begin
            bad++;
            $display("FAIL badsize_consumed got %0d want %0d", dbg_wr_beats, exp_wr);
        end
        axi_read(BASE + 32'h190, 4'd1, 3'd3, 1'b0);
        total++;
        if (rdv[0] !== 64'h55) begin bad++; $display("FAIL badsize_ram got %h want 55", rdv[0]); end
        axi_read(BASE + 32'h190, 4'd0, 3'd2, 1'b0);
        total++;
        if (rdv[0] !== 64'd0 || rrv[0] !== 2'b10) begin
            bad++;
            $display("FAIL badsize_read got data=%h resp=%b want 0 10", rdv[0], rrv[0]);
        end
    endtask

    task automatic test_wlast_err();
        logic [1:0] resp;
        for (int i = 0; i < 4; i++) wd[i] = 64'h77 + 64'(i);
        axi_write(BASE + 32'h200, 4'd3, 3'd3, 2, 8'hFF, resp);
        total++;
        if (resp !== 2'b10) begin bad++; $display("FAIL early_wlast got %b want 10", resp); end
        axi_write(BASE + 32'h200, 4'd1, 3'd3, 3, 8'hFF, resp);
        total++;
        if (resp !== 2'b10) begin bad++; $display("FAIL late_wlast got %b want 10", resp); end
        total++;
        if (dbg_wr_beats !== 32'(exp_wr) || dbg_rd_beats !== 32'(exp_rd)) begin
            bad++;
            $display("FAIL dbg_counts got wr=%0d rd=%0d want %0d %0d",
                     dbg_wr_beats, dbg_rd_beats, exp_wr, exp_rd);
        end
    endtask

    task automatic test_reset_mid_read();
        int n, k, stray;
        bus.S_AXI_ARADDR  = BASE + 32'h100;
        bus.S_AXI_ARLEN   = 4'd7;
        bus.S_AXI_ARSIZE  = 3'd3;
        bus.S_AXI_ARBURST = 2'b01;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY  = 1'b1;
        n = 0;
        while (!bus.S_AXI_ARREADY && n < 50) begin @(negedge fclk); n++; end
        @(negedge fclk);
        bus.S_AXI_ARVALID = 1'b0;
        k = 0; n = 0;
        while (k < 3 && n < 50) begin
            if (bus.S_AXI_RVALID) k++;
            @(negedge fclk);
            n++;
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_RLAST !== 1'b0) begin
            bad++;
            $display("FAIL midrst_rvalid got rvalid=%b rlast=%b want 0 0", bus.S_AXI_RVALID, bus.S_AXI_RLAST);
        end
        @(negedge fclk);
        @(negedge fclk);
        rst = 1'b0;
        @(negedge fclk);
        total++;
        if (bus.S_AXI_ARREADY !== 1'b1 || dbg_rd_beats !== 32'd0) begin
            bad++;
            $display("FAIL midrst_release got arready=%b dbg_rd=%0d want 1 0", bus.S_AXI_ARREADY, dbg_rd_beats);
        end
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_RLAST !== 1'b0) stray++;
            @(negedge fclk);
        end
        bus.S_AXI_RREADY = 1'b0;
        total++;
        if (stray != 0) begin bad++; $display("FAIL midrst_stray got %0d stray cycles want 0", stray); end
    endtask

    initial begin
        rst = 1'b1;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWSIZE = 3'd3;
        bus.S_AXI_AWBURST = 2'b01; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARSIZE = 3'd3;
        bus.S_AXI_ARBURST = 2'b01; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
        @(negedge fclk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_rready_toggle();
        test_strobe();
        test_range_edge();
        test_bad_size();
        test_wlast_err();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
